// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
// Bundles the signals between the partial-sum accumulator and its neighbours:
// the start/config strobe, the adder-tree side (enable, valid, tree output,
// upstream_ready) and the output stream toward the output buffer writer
// (out_data/out_valid/out_ready), plus the busy and ovf_err status flags.
//   master : drives start, cfg_*, adder_enable, tree_in_valid,
//            adder_tree_out, out_ready
//   slave  : drives upstream_ready, out_data, out_valid, busy, ovf_err
interface psum_accumulator_if #(
  parameter int WID_IN  = 16,
  parameter int WID_ACC = 32,
  parameter int WID_OUT = 16,
  parameter int CH_W    = 8
);

  logic                start;
  logic [CH_W-1:0]     cfg_num_ch;
  logic [WID_ACC-1:0]  cfg_bias;
  logic                cfg_relu;
  logic [4:0]          cfg_shift;
  logic                adder_enable;
  logic                tree_in_valid;
  logic [WID_IN-1:0]   adder_tree_out;
  logic                upstream_ready;
  logic [WID_OUT-1:0]  out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  logic                ovf_err;

  modport master (
    output start, cfg_num_ch, cfg_bias, cfg_relu, cfg_shift,
    output adder_enable, tree_in_valid, adder_tree_out, out_ready,
    input  upstream_ready, out_data, out_valid, busy, ovf_err
  );

  modport slave (
    input  start, cfg_num_ch, cfg_bias, cfg_relu, cfg_shift,
    input  adder_enable, tree_in_valid, adder_tree_out, out_ready,
    output upstream_ready, out_data, out_valid, busy, ovf_err
  );

endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator
// Sits behind the pooling/NL adder tree. A valid-tracking shift register
// follows real samples through the tree, the accumulator sums cfg_num_ch
// samples per result, a finish stage adds bias, applies optional ReLU,
// round-half-up shifts and saturates, and the result is queued in a small
// output FIFO. upstream_ready throttles new tree inputs so that every sample
// already inside the tree still has a FIFO slot when it finishes.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : psum_accumulator_if.slave (config, tree side, output stream,
//              status flags)
module psum_accumulator #(
  parameter int WID_IN     = 16,
  parameter int WID_ACC    = 32,
  parameter int WID_OUT    = 16,
  parameter int TREE_LAT   = 5,
  parameter int CH_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  psum_accumulator_if.slave bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + TREE_LAT + 2) + 1;
  localparam int SUM_W = WID_ACC + 1;
  localparam int RND_W = WID_ACC + 2;

  localparam logic signed [RND_W-1:0] OUT_MAX =
    {{(RND_W - WID_OUT + 1){1'b0}}, {(WID_OUT-1){1'b1}}};
  localparam logic signed [RND_W-1:0] OUT_MIN =
    {{(RND_W - WID_OUT + 1){1'b1}}, {(WID_OUT-1){1'b0}}};

  // Configuration latched by start
  logic [CH_W-1:0]    cfgNumCh_q, cfgNumCh_d;
  logic [WID_ACC-1:0] cfgBias_q, cfgBias_d;
  logic               cfgRelu_q, cfgRelu_d;
  logic [4:0]         cfgShift_q, cfgShift_d;

  // Valid tracking through the adder tree
  logic [TREE_LAT-1:0] pipe_q, pipe_d;
  logic                enPrev_q, enPrev_d;

  // Accumulation and finish stage
  logic [WID_ACC-1:0] acc_q, acc_d;
  logic [CH_W-1:0]    chCnt_q, chCnt_d;
  logic               fin_q, fin_d;

  // Output FIFO
  logic [WID_OUT-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wrPtr_q, wrPtr_d;
  logic [AW-1:0]      rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               upReady_q, upReady_d;

  logic               sampleValid;
  logic               lastSample;
  logic [CH_W-1:0]    numEffM1;
  logic [WID_ACC-1:0] sampleExt;
  logic               fifoFull;
  logic               doPush;
  logic               doPop;
  logic [OCC_W-1:0]   inflight;
  logic [OCC_W-1:0]   occupancy;

  logic signed [SUM_W-1:0] finSum;
  logic signed [RND_W-1:0] finRoundInc;
  logic signed [RND_W-1:0] finRounded;
  logic signed [RND_W-1:0] finShifted;
  logic [WID_OUT-1:0]      finResult;

  // The pipe tail only marks a fresh sample on the cycle right after an
  // enabled edge; when the tree is stalled the tail bit is stale. A sample
  // landing in the same cycle as start belongs to the old job and is dropped.
  always_comb begin
    sampleValid = pipe_q[TREE_LAT-1] && enPrev_q && !bus.start;
    numEffM1    = (cfgNumCh_q == '0) ? '0 : cfgNumCh_q - CH_W'(1);
    lastSample  = sampleValid && (chCnt_q == numEffM1);
    sampleExt   = {{(WID_ACC-WID_IN){bus.adder_tree_out[WID_IN-1]}}, bus.adder_tree_out};
  end

  // Finish datapath: bias, ReLU, round-half-up shift, saturation. The sum is
  // kept one bit wider than the accumulator and the rounding one more, so
  // only the final saturation can clip.
  always_comb begin
    finSum = $signed({acc_q[WID_ACC-1], acc_q}) + $signed({cfgBias_q[WID_ACC-1], cfgBias_q});
    if (cfgRelu_q && finSum[SUM_W-1]) begin
      finSum = '0;
    end
    finRoundInc = '0;
    if (cfgShift_q != 5'd0) begin
      finRoundInc = RND_W'(1) << (cfgShift_q - 5'd1);
    end
    finRounded = $signed({finSum[SUM_W-1], finSum}) + finRoundInc;
    finShifted = finRounded >>> cfgShift_q;
    if (finShifted > OUT_MAX) begin
      finResult = {1'b0, {(WID_OUT-1){1'b1}}};
    end else if (finShifted < OUT_MIN) begin
      finResult = {1'b1, {(WID_OUT-1){1'b0}}};
    end else begin
      finResult = finShifted[WID_OUT-1:0];
    end
  end

  // Next-state logic for config, valid pipe, accumulator and finish flag
  always_comb begin
    cfgNumCh_d = cfgNumCh_q;
    cfgBias_d  = cfgBias_q;
    cfgRelu_d  = cfgRelu_q;
    cfgShift_d = cfgShift_q;
    pipe_d     = pipe_q;
    enPrev_d   = bus.adder_enable;
    acc_d      = acc_q;
    chCnt_d    = chCnt_q;
    fin_d      = lastSample;

    if (bus.start) begin
      cfgNumCh_d = bus.cfg_num_ch;
      cfgBias_d  = bus.cfg_bias;
      cfgRelu_d  = bus.cfg_relu;
      cfgShift_d = bus.cfg_shift;
      pipe_d     = '0;
      acc_d      = '0;
      chCnt_d    = '0;
    end else begin
      if (bus.adder_enable) begin
        pipe_d = {pipe_q[TREE_LAT-2:0], bus.tree_in_valid};
      end
      if (sampleValid) begin
        acc_d   = (chCnt_q == '0) ? sampleExt : acc_q + sampleExt;
        chCnt_d = lastSample ? '0 : chCnt_q + CH_W'(1);
      end
    end
  end

  // FIFO control and flow control. A push while full is still accepted when
  // a pop happens the same cycle; otherwise it is dropped and flagged. A drop
  // coinciding with start still sets the flag because the result is lost.
  // upstream_ready is registered from next-state occupancy (FIFO entries,
  // samples in the tree, result in the finish stage), so the value seen in a
  // cycle already accounts for everything that can still land in the FIFO.
  always_comb begin
    fifoFull = (count_q == CNT_W'(FIFO_DEPTH));
    doPop    = (count_q != '0) && bus.out_ready;
    doPush   = fin_q && (!fifoFull || doPop);
    ovf_d    = bus.start ? 1'b0 : ovf_q;
    if (fin_q && fifoFull && !doPop) begin
      ovf_d = 1'b1;
    end
    wrPtr_d = wrPtr_q + AW'(doPush);
    rdPtr_d = rdPtr_q + AW'(doPop);
    count_d = count_q + CNT_W'(doPush) - CNT_W'(doPop);

    inflight = '0;
    for (int i = 0; i < TREE_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe_d[i]);
    end
    occupancy = OCC_W'(count_d) + inflight + OCC_W'(fin_d);
    upReady_d = (occupancy < OCC_W'(FIFO_DEPTH));
  end

  // State registers, all cleared (FIFO contents included) by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfgNumCh_q <= CH_W'(1);
      cfgBias_q  <= '0;
      cfgRelu_q  <= 1'b0;
      cfgShift_q <= '0;
      pipe_q     <= '0;
      enPrev_q   <= 1'b0;
      acc_q      <= '0;
      chCnt_q    <= '0;
      fin_q      <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      upReady_q  <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cfgNumCh_q <= cfgNumCh_d;
      cfgBias_q  <= cfgBias_d;
      cfgRelu_q  <= cfgRelu_d;
      cfgShift_q <= cfgShift_d;
      pipe_q     <= pipe_d;
      enPrev_q   <= enPrev_d;
      acc_q      <= acc_d;
      chCnt_q    <= chCnt_d;
      fin_q      <= fin_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      upReady_q  <= upReady_d;
      if (doPush) begin
        mem_q[wrPtr_q] <= finResult;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.out_data       = mem_q[rdPtr_q];
    bus.out_valid      = (count_q != '0);
    bus.busy           = (|pipe_q) || (chCnt_q != '0) || fin_q;
    bus.ovf_err        = ovf_q;
    bus.upstream_ready = upReady_q;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
// Directed and randomized stimulus for psum_accumulator. A reference model
// tracks each issued tree sample by the enabled-edge count at which it leaves
// the tree, accumulates samples with plain integer arithmetic, and queues
// expected results with the cycle they should become visible.
module tb_psum_accumulator;

  localparam int TREE_LAT   = 5;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;

  psum_accumulator_if pif ();

  psum_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (pif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          readyCyc;
  } result_t;

  int      testsRun    = 0;
  int      testsFailed = 0;
  result_t expQ[$];
  int      pendQ[$];
  logic [15:0] dataQ[$];
  int      cyc     = 0;
  int      enCnt   = 0;
  int      lastIdx = -1;
  bit      lastEn  = 1'b0;
  int      mNumEff = 1;
  longint  mBias   = 0;
  bit      mRelu   = 1'b0;
  int      mShift  = 0;
  longint  mAcc    = 0;
  int      mCnt    = 0;
  int      issued  = 0;
  int      popped  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Bias, ReLU, round half up, saturate to 16 bits
  function automatic logic [15:0] refResult(input longint accSum);
    int     a32;
    longint s;
    a32 = int'(accSum);
    s   = longint'(a32) + mBias;
    if (mRelu && s < 0) s = 0;
    if (mShift > 0) begin
      s = s + (longint'(1) <<< (mShift - 1));
      s = s >>> mShift;
    end
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  // One clock cycle: check outputs, update model, drive inputs, advance
  task automatic applyStimulus(input bit en, input bit wantValid, input bit rdy,
                               input bit st, input bit chkReady);
    bit          expValid;
    bit          sampleNow;
    bit          v;
    logic [15:0] data;
    expValid = (expQ.size() > 0) && (expQ[0].readyCyc <= cyc);
    checkOutput("out_valid", 32'(pif.out_valid), 32'(expValid));
    if (chkReady)
      checkOutput("upstream_ready", 32'(pif.upstream_ready), 32'((issued - popped) < FIFO_DEPTH));
    if (expValid && rdy) begin
      checkOutput("out_data", 32'(pif.out_data), 32'(expQ[0].val));
      void'(expQ.pop_front());
      popped++;
    end
    sampleNow = lastEn && (pendQ.size() > 0) && (pendQ[0] == lastIdx);
    data = 16'($urandom);
    if (sampleNow) begin
      void'(pendQ.pop_front());
      if (dataQ.size() > 0) data = dataQ.pop_front();
      if (!st) begin
        if (mCnt == 0) mAcc = longint'(shortint'(data));
        else mAcc = mAcc + longint'(shortint'(data));
        mCnt++;
        if (mCnt == mNumEff) begin
          expQ.push_back('{val: refResult(mAcc), readyCyc: cyc + 2});
          mCnt = 0;
        end
      end
    end
    v = wantValid && pif.upstream_ready;
    pif.adder_tree_out = data;
    pif.adder_enable   = en;
    pif.tree_in_valid  = v;
    pif.out_ready      = rdy;
    pif.start          = st;
    if (st) begin
      pendQ.delete();
      mCnt   = 0;
      mAcc   = 0;
      issued = 0;
      popped = 0;
    end else if (en && v) begin
      pendQ.push_back(enCnt + TREE_LAT - 1);
      issued++;
    end
    if (en) begin
      lastIdx = enCnt;
      enCnt++;
    end
    lastEn = en;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    pif.start = 1'b0;
  endtask

  task automatic startRun(input int num, input int bias, input bit relu, input int shift);
    pif.cfg_num_ch = 8'(num);
    pif.cfg_bias   = 32'(bias);
    pif.cfg_relu   = relu;
    pif.cfg_shift  = 5'(shift);
    mNumEff = (num == 0) ? 1 : num;
    mBias   = longint'(bias);
    mRelu   = relu;
    mShift  = shift;
    dataQ.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain(input int maxCyc);
    int n;
    n = 0;
    while ((expQ.size() > 0 || pendQ.size() > 0) && n < maxCyc) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("drain_left", 32'(expQ.size() + pendQ.size()), 32'd0);
    checkOutput("busy_after_drain", 32'(pif.busy), 32'(mCnt != 0));
  endtask

  task automatic issueSamples(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    pif.start = 1'b0;
    pif.cfg_num_ch = '0;
    pif.cfg_bias = '0;
    pif.cfg_relu = 1'b0;
    pif.cfg_shift = '0;
    pif.adder_enable = 1'b0;
    pif.tree_in_valid = 1'b0;
    pif.adder_tree_out = '0;
    pif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(pif.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(pif.out_data), 32'd0);
    checkOutput("rst_busy", 32'(pif.busy), 32'd0);
    checkOutput("rst_ovf", 32'(pif.ovf_err), 32'd0);
    checkOutput("rst_upstream_ready", 32'(pif.upstream_ready), 32'd1);
    rst = 1'b0;

    // Pass-through, one sample per result
    startRun(1, 0, 1'b0, 0);
    dataQ = '{16'd10, 16'hFFFD, 16'h7FFF};
    issueSamples(3);
    drain(30);

    // Four channels with bias and shift
    startRun(4, 100, 1'b0, 2);
    dataQ = '{16'd50, 16'd60, 16'd70, 16'd80};
    issueSamples(4);
    drain(30);

    // ReLU clamp, then same sum negative with rounding shift
    startRun(2, 0, 1'b1, 0);
    dataQ = '{16'hFE0C, 16'd100};
    issueSamples(2);
    drain(30);
    startRun(2, 0, 1'b0, 1);
    dataQ = '{16'hFE0C, 16'd100};
    issueSamples(2);
    drain(30);

    // Saturation at both ends
    startRun(4, 0, 1'b0, 0);
    dataQ = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    issueSamples(4);
    drain(30);
    startRun(4, 0, 1'b0, 0);
    dataQ = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    issueSamples(4);
    drain(30);

    // Backpressure: consumer stalled, continuous offered input
    startRun(1, 0, 1'b0, 0);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_ovf", 32'(pif.ovf_err), 32'd0);
    checkOutput("bp_issued", 32'(issued), 32'(FIFO_DEPTH));
    repeat (15) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("bp_popped", 32'(popped), 32'(FIFO_DEPTH));
    checkOutput("bp_ovf_end", 32'(pif.ovf_err), 32'd0);

    // Tree enable toggling every cycle
    startRun(1, 0, 1'b0, 0);
    for (int i = 0; i < 14; i++) applyStimulus(i % 2 == 0, i % 2 == 0, 1'b1, 1'b0, 1'b0);
    drain(40);

    // Async reset with one queued result and a partial accumulation
    startRun(4, 0, 1'b0, 0);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("pre_rst_busy", 32'(pif.busy), 32'(mCnt != 0));
    checkOutput("pre_rst_valid", 32'(pif.out_valid), 32'(expQ.size() > 0));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(pif.out_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(pif.busy), 32'd0);
    checkOutput("mid_rst_upstream_ready", 32'(pif.upstream_ready), 32'd1);
    expQ.delete();
    pendQ.delete();
    dataQ.delete();
    mCnt = 0;
    mAcc = 0;
    lastEn = 1'b0;
    mNumEff = 1;
    mBias = 0;
    mRelu = 1'b0;
    mShift = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;

    // Randomized runs, including a start while samples are in flight
    for (int r = 0; r < 4; r++) begin
      startRun(int'($urandom_range(0, 5)), int'($urandom_range(0, 2000)) - 1000,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
      for (int k = 0; k < 60; k++) begin
        if (k == 30)
          startRun(int'($urandom_range(0, 5)), int'($urandom_range(0, 2000)) - 1000,
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
        else
          applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) != 0, 1'b0, 1'b0);
      end
      drain(200);
      checkOutput("rand_ovf", 32'(pif.ovf_err), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
